ffm: RTL
========

# ffm

Sequential finite-field multiplier over GF(p), p = 2^255 − 19, for the ECC scalar-multiplication datapath. It is the forward-direction counterpart of the field inverter: the point add/double sequencer uses it for every field product, and the affine-conversion step uses it to apply the inverter's result. It computes prod = a·b mod p with an MSB-first interleaved double-and-add loop, one bit per cycle. Requests use a start/busy/valid handshake.

## Interface
- `P` — default 2^255 − 19, zero-extended to 256 bits — field modulus.
- `W` — default 255 — operand and result width.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `start` input 1 — request strobe, sampled only in IDLE.
- `a` input 255 — multiplicand; must be < p unless the configuration macro is defined.
- `b` input 255 — multiplier; scanned from bit 254 down to bit 0.
- `prod` output 255 — a·b mod p; held stable until the next accepted start.
- `valid` output 1 — high when `prod` holds the result of the last accepted request.
- `busy` output 1 — high in RUN and DONE.

## Operation
- States:
  - IDLE: if `start`, latch a→`a_r` and b→`b_r`, set acc=0, cnt=254, clear `valid`, go to RUN.
  - RUN: acc ← step(acc, `a_r`, `b_r[cnt]`); decrement cnt; go to DONE after the cnt==0 iteration.
  - DONE: prod ← acc[254:0], valid ← 1, go to IDLE.
- step, on a 256-bit acc:
  - d = acc<<1; if d ≥ P then d −= P.
  - s = d + (bit ? a_r : 0); if s ≥ P then s −= P.
  - Invariant: acc < p after every iteration.
  - All intermediate values fit in 256 bits because acc and a_r are both < 2^255.
- `start` outside IDLE is ignored; no queueing.
- `start` held high across DONE→IDLE launches a new request on the first IDLE cycle.
- Operands are captured at the accepted edge. Changes to `a`/`b` afterward do not affect the current result.
- Boundaries:
  - b = 0 or a = 0 → prod = 0.
  - (p−1)·(p−1) → 1.
  - No result may ever equal or exceed p.

## Timing
- Reset values: prod=0, valid=0, busy=0, state=IDLE, acc=0, cnt=0.
- Reset asserted mid-operation aborts immediately. No valid pulse follows, and the next request starts cleanly.
- Edge E0 accepts start. E1..E255 perform the 255 iterations. E256 (DONE) registers prod and valid. `valid` is high after E256: 256-cycle latency.
- `busy` is high from after E0 through E256. It is low in the cycle `valid` first rises, so a new start can be accepted at E257.
- Throughput: one product per 257 cycles with back-to-back starts.
- `valid` stays high until the next accepted start, and is cleared at that edge.

## Configuration
- `FFM_REDUCE_INPUTS_EN` defined:
  - At the accept edge, each operand ≥ p is replaced by operand − p.
  - This is a single conditional subtraction, so every 255-bit input is legal.
  - Latency is unchanged.
- `FFM_REDUCE_INPUTS_EN` undefined:
  - Operands are latched as-is.
  - Inputs ≥ p give an unspecified result; the bench must not drive them.

## Structure
- `ecc_pkg`, shared with the inverter and sequencer, holds:
  - field width `W`;
  - modulus constant `P` (256-bit);
  - state enum `ffm_state_t` {IDLE, RUN, DONE}.
- One combinational sub-module, `ffm_addmod`: 256-bit add plus a single conditional subtract of P. It is instantiated twice per step: the doubling (x+x) and the accumulate (d + a_r or d + 0).

## Test plan
- a=2, b=3, pulse start → after 256 cycles valid=1, prod=6, busy=0.
- a=p−1, b=p−1 → prod=1. Also a=2, b=2^254−9 → prod=1, cross-checking the inverter's output for a=2.
- a=0, b=p−1 → prod=0. Then a=p−1, b=0 → prod=0. valid toggles low at each accepted start.
- Start a=5, b=7. Pulse start again with a=9, b=9 at cycle 100, and change `a` mid-run → prod=35 at cycle 256 with a single completion.
- Start a=2, b=3; drive rst=0 at cycle 50 → prod=0, valid=0, busy=0 asynchronously. Release, then a=4, b=4 → prod=16 at 256 cycles.
- With `FFM_REDUCE_INPUTS_EN`: a=p+2, b=3 → prod=6. Also run 10,000 random operand pairs (< p) against a reference model, back-to-back starts, with no mismatch.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - GF(2^255-19) field constants, FSM state type and input reduction helper
package ecc_pkg;

   localparam int W = 255;
   localparam logic [255:0] P = 256'((256'd1 << 255) - 256'd19);

   typedef enum logic [1:0] {IDLE, RUN, DONE} ffm_state_t;

   // Any 255-bit value is below 2p, so one conditional subtract lands it in [0, p).
   function automatic logic [W-1:0] reduce_once(input logic [W-1:0] x);
      logic [255:0] xe;
      xe = {1'b0, x};
      return (xe >= P) ? W'(xe - P) : x;
   endfunction

endpackage

// File: rtl/ffm_if.sv
// rtl/ffm_if.sv - start/busy/valid request bus for the field multiplier
interface ffm_if;
   import ecc_pkg::*;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] prod;
   logic         valid;
   logic         busy;

   modport master (output start, a, b, input prod, valid, busy);
   modport slave  (input start, a, b, output prod, valid, busy);

endinterface

// File: rtl/ffm_addmod.sv
// rtl/ffm_addmod.sv - 256-bit modular add with a single conditional subtract of P
module ffm_addmod
   import ecc_pkg::*;
(
   input  logic [255:0] x,
   input  logic [255:0] y,
   output logic [255:0] s
);

   logic [255:0] sum;

   // Both operands are < p, so the raw sum always fits in 256 bits.
   assign sum = x + y;
   assign s   = (sum >= P) ? (sum - P) : sum;

endmodule

// File: rtl/ffm.sv
// rtl/ffm.sv - sequential MSB-first double-and-add multiplier over GF(2^255-19); option FFM_REDUCE_INPUTS_EN
module ffm
   import ecc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   ffm_if.slave bus
);

   ffm_state_t   state, state_nx;
   logic [W-1:0] a_r, b_r, prod_r, a_in, b_in;
   logic [255:0] acc, dbl, addend, nxt;
   logic [7:0]   cnt;
   logic         valid_r;

`ifdef FFM_REDUCE_INPUTS_EN
   assign a_in = reduce_once(bus.a);
   assign b_in = reduce_once(bus.b);
`else
   assign a_in = bus.a;
   assign b_in = bus.b;
`endif

   assign addend = b_r[cnt] ? {1'b0, a_r} : 256'd0;

   ffm_addmod u_dbl (.x(acc), .y(acc),    .s(dbl));
   ffm_addmod u_acc (.x(dbl), .y(addend), .s(nxt));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (cnt == 8'd0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r     <= '0;
         b_r     <= '0;
         acc     <= '0;
         cnt     <= '0;
         prod_r  <= '0;
         valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               a_r     <= a_in;
               b_r     <= b_in;
               acc     <= '0;
               cnt     <= 8'(W - 1);
               valid_r <= 1'b0;
            end
            RUN: begin
               acc <= nxt;
               if (cnt != 8'd0) cnt <= cnt - 8'd1;
            end
            DONE: begin
               prod_r  <= acc[W-1:0];
               valid_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.prod  = prod_r;
   assign bus.valid = valid_r;
   assign bus.busy  = (state != IDLE);

endmodule
